// File: rtl/video_pkg.sv
// Shared constants and types for the sprite scanline buffer.
package video_pkg;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned X_W    = 9;
  localparam int unsigned ADDR_W = $clog2(2 * LINE_W);

  localparam logic [3:0]       PEN_TRANSPARENT = 4'hF;
  localparam logic [PIX_W-1:0] PIX_CLEAR       = 8'h0F;

  typedef enum logic {
    INIT,
    RUN
  } lb_state_e;

endpackage

// File: rtl/sprite_line_buffer_if.sv
// Video timing, renderer write and mixer output signals of the line buffer.
interface sprite_line_buffer_if;

  logic                           clk_pix;
  logic [video_pkg::X_W-1:0]      hc;
  logic                           hbl;
  logic                           vbl;
  logic                           wr_en;
  logic [video_pkg::X_W-1:0]      wr_x;
  logic [video_pkg::PIX_W-1:0]    wr_data;
  logic                           ready;
  logic                           line_start;
  logic [video_pkg::PIX_W-1:0]    pix_out;
  logic                           pix_valid;

  modport master (
    output clk_pix, hc, hbl, vbl, wr_en, wr_x, wr_data,
    input  ready, line_start, pix_out, pix_valid
  );

  modport slave (
    input  clk_pix, hc, hbl, vbl, wr_en, wr_x, wr_data,
    output ready, line_start, pix_out, pix_valid
  );

endinterface

// File: rtl/line_ram.sv
// Two-bank scanline RAM: port A read-first read/write, port B write-only.
module line_ram
  import video_pkg::*;
(
  input  logic              clk,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [PIX_W-1:0]  a_wdata,
  output logic [PIX_W-1:0]  a_rdata,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [PIX_W-1:0]  b_wdata
);

  logic [PIX_W-1:0] mem [2*LINE_W];

  // Synchronous access; the two ports never address the same bank.
  always_ff @(posedge clk) begin
    if (a_en) begin
      a_rdata <= mem[a_addr];
      if (a_we) begin
        mem[a_addr] <= a_wdata;
      end
    end
    if (b_we) begin
      mem[b_addr] <= b_wdata;
    end
  end

endmodule

// File: rtl/sprite_line_buffer.sv
// Ping-pong sprite scanline buffer with clear-behind display reads.
module sprite_line_buffer
  import video_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  sprite_line_buffer_if.slave   bus
);

  lb_state_e         state;
  logic [ADDR_W-1:0] sweep;
  logic              sel;
  logic              hbl_d;
  logic              rd_pend;
  logic              blk_pend;
  logic              vbl_pend;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  ram_rdata;

  logic              swap_c;
  logic              rd_c;
  logic              sel_nxt_c;
  logic              wr_ok_c;
  logic              a_en_c;
  logic              a_we_c;
  logic [ADDR_W-1:0] a_addr_c;
  logic              b_we_c;
  logic [ADDR_W-1:0] b_addr_c;
  logic [PIX_W-1:0]  b_wdata_c;

  // Port steering: display read/clear on A, sweep or renderer writes on B.
  always_comb begin
    swap_c    = (state == RUN) && bus.clk_pix && bus.hbl && !hbl_d;
    rd_c      = (state == RUN) && bus.clk_pix && !bus.hbl && (bus.hc < X_W'(LINE_W));
    sel_nxt_c = sel ^ swap_c;
    wr_ok_c   = bus.wr_en && (bus.wr_x < X_W'(LINE_W)) &&
                (bus.wr_data[3:0] != PEN_TRANSPARENT);

    a_en_c    = 1'b0;
    a_we_c    = 1'b0;
    a_addr_c  = {sel, bus.hc[ADDR_W-2:0]};
    if (rd_pend) begin
      a_en_c   = 1'b1;
      a_we_c   = 1'b1;
      a_addr_c = rd_addr;
    end else if (rd_c) begin
      a_en_c   = 1'b1;
    end

    // A write in the swap cycle already targets the bank being released.
    b_we_c    = wr_ok_c && (state == RUN);
    b_addr_c  = {~sel_nxt_c, bus.wr_x[ADDR_W-2:0]};
    b_wdata_c = bus.wr_data;
    if (state == INIT) begin
      b_we_c    = 1'b1;
      b_addr_c  = sweep;
      b_wdata_c = PIX_CLEAR;
    end
  end

  line_ram u_ram (
    .clk     (clk),
    .a_en    (a_en_c),
    .a_we    (a_we_c),
    .a_addr  (a_addr_c),
    .a_wdata (PIX_CLEAR),
    .a_rdata (ram_rdata),
    .b_we    (b_we_c),
    .b_addr  (b_addr_c),
    .b_wdata (b_wdata_c)
  );

  // FSM, clear sweep, bank swap and registered display outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= INIT;
      sweep          <= '0;
      sel            <= 1'b0;
      hbl_d          <= 1'b0;
      rd_pend        <= 1'b0;
      blk_pend       <= 1'b0;
      vbl_pend       <= 1'b0;
      rd_addr        <= '0;
      bus.ready      <= 1'b0;
      bus.line_start <= 1'b0;
      bus.pix_out    <= '0;
      bus.pix_valid  <= 1'b0;
    end else begin
      bus.line_start <= 1'b0;
      rd_pend        <= 1'b0;
      blk_pend       <= 1'b0;
      if (bus.clk_pix) begin
        hbl_d <= bus.hbl;
      end
      case (state)
        INIT: begin
          sweep <= sweep + 1'b1;
          if (sweep == ADDR_W'(2 * LINE_W - 1)) begin
            state     <= RUN;
            bus.ready <= 1'b1;
          end
        end
        RUN: begin
          if (swap_c) begin
            sel            <= ~sel;
            bus.line_start <= 1'b1;
          end
          if (rd_c) begin
            rd_pend  <= 1'b1;
            rd_addr  <= a_addr_c;
            vbl_pend <= bus.vbl;
          end
          if (bus.clk_pix && bus.hbl) begin
            blk_pend <= 1'b1;
          end
          // Transparent pixels present as 0 to the mixer.
          if (rd_pend) begin
            bus.pix_out   <= (vbl_pend || ram_rdata[3:0] == PEN_TRANSPARENT) ? '0 : ram_rdata;
            bus.pix_valid <= ~vbl_pend;
          end else if (blk_pend) begin
            bus.pix_out   <= '0;
            bus.pix_valid <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_line_buffer.sv
`timescale 1ns/1ps
module tb_sprite_line_buffer;
  import video_pkg::*;

  localparam int LINE_TOT = 264;

  logic clk = 1'b0;
  logic reset_n;
  sprite_line_buffer_if bus();

  sprite_line_buffer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the line being shown and the line being drawn.
  logic [7:0] disp [LINE_W];
  logic [7:0] draw [LINE_W];
  bit         m_hbl_prev;
  typedef struct { int x; logic [7:0] d; } wr_t;
  wr_t        wq[$];
  bit         swap_wr;
  int         swap_x;
  logic [7:0] swap_d;
  bit         pend;
  int         pend_h;
  logic [7:0] exp_pix;
  logic       exp_pv;
  bit         ls_chk;
  logic [7:0] cap_pix [LINE_W];
  logic       cap_pv  [LINE_W];

  task automatic model_reset();
    for (int i = 0; i < LINE_W; i++) begin
      disp[i] = 8'h0F;
      draw[i] = 8'h0F;
    end
    m_hbl_prev = 1'b0;
    pend = 1'b0;
    ls_chk = 1'b0;
    swap_wr = 1'b0;
    wq.delete();
  endtask

  task automatic model_write(input int x, input logic [7:0] d);
    if (x < LINE_W && d[3:0] != 4'hF) draw[x] = d;
  endtask

  task automatic do_reset(input bit noisy, output int n);
    bus.clk_pix = 1'b0; bus.hc = '0; bus.hbl = 1'b0; bus.vbl = 1'b0;
    bus.wr_en = 1'b0; bus.wr_x = '0; bus.wr_data = '0;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    if (noisy) begin
      bus.wr_en = 1'b1; bus.wr_x = 9'd3; bus.wr_data = 8'h31;
    end
    n = 0;
    while (n < 600) begin
      @(posedge clk); #1;
      n++;
      if (bus.ready === 1'b1) break;
    end
    bus.wr_en = 1'b0;
  endtask

  // Drive one line of pixels (clk_pix every 2 clk), checking each against the model.
  task automatic run_line(input bit v, input int stop);
    for (int h = 0; h <= stop; h++) begin
      bit hb;
      bit sw;
      logic [7:0] val;
      @(negedge clk);
      bus.wr_en = 1'b0;
      if (pend) begin
        checks++;
        if (bus.pix_out !== exp_pix || bus.pix_valid !== exp_pv) begin
          errors++;
          $display("FAIL pixel hc=%0d: got pix=%h valid=%b, want pix=%h valid=%b",
                   pend_h, bus.pix_out, bus.pix_valid, exp_pix, exp_pv);
        end
        if (pend_h < LINE_W) begin
          cap_pix[pend_h] = bus.pix_out;
          cap_pv[pend_h]  = bus.pix_valid;
        end
        pend = 1'b0;
      end
      if (ls_chk) begin
        checks++;
        if (bus.line_start !== 1'b0) begin
          errors++;
          $display("FAIL line_start_width: got %b, want 0", bus.line_start);
        end
        ls_chk = 1'b0;
      end
      if (h == stop) break;
      hb = (h >= LINE_W);
      sw = hb && !m_hbl_prev;
      m_hbl_prev = hb;
      bus.clk_pix = 1'b1; bus.hc = 9'(h); bus.hbl = hb; bus.vbl = v;
      if (!hb) begin
        val = disp[h];
        exp_pix = (v || val[3:0] == 4'hF) ? 8'h00 : val;
        exp_pv = !v;
        disp[h] = 8'h0F;
      end else begin
        exp_pix = 8'h00;
        exp_pv = 1'b0;
      end
      pend = 1'b1;
      pend_h = h;
      if (sw) begin
        for (int i = 0; i < LINE_W; i++) begin
          val = disp[i]; disp[i] = draw[i]; draw[i] = val;
        end
        if (swap_wr) begin
          bus.wr_en = 1'b1; bus.wr_x = 9'(swap_x); bus.wr_data = swap_d;
          model_write(swap_x, swap_d);
          swap_wr = 1'b0;
        end
      end
      @(negedge clk);
      bus.clk_pix = 1'b0;
      bus.wr_en = 1'b0;
      if (sw) begin
        checks++;
        if (bus.line_start !== 1'b1) begin
          errors++;
          $display("FAIL line_start_pulse: got %b, want 1", bus.line_start);
        end
        ls_chk = 1'b1;
      end
      if (wq.size() > 0) begin
        wr_t w;
        w = wq.pop_front();
        bus.wr_en = 1'b1; bus.wr_x = 9'(w.x); bus.wr_data = w.d;
        model_write(w.x, w.d);
      end
    end
  endtask

  function automatic int count_non_blank();
    int c = 0;
    for (int i = 0; i < LINE_W; i++)
      if (cap_pix[i] !== 8'h00 || cap_pv[i] !== 1'b1) c++;
    return c;
  endfunction

  task automatic test_reset();
    int n;
    reset_n = 1'b0;
    bus.clk_pix = 1'b0; bus.wr_en = 1'b0;
    #1;
    checks++;
    if ({bus.ready, bus.line_start, bus.pix_valid, bus.pix_out} !== 11'b0) begin
      errors++;
      $display("FAIL reset_values: got ready=%b ls=%b pv=%b pix=%h, want all 0",
               bus.ready, bus.line_start, bus.pix_valid, bus.pix_out);
    end
    do_reset(1'b1, n);
    checks++;
    if (n != 512) begin
      errors++;
      $display("FAIL ready_rise: got cycle %0d, want 512", n);
    end
  endtask

  task automatic test_first_line();
    for (int l = 0; l < 2; l++) begin
      run_line(1'b0, LINE_TOT);
      checks++;
      if (count_non_blank() != 0) begin
        errors++;
        $display("FAIL first_line_%0d: got %0d non-blank pixels, want 0", l, count_non_blank());
      end
    end
  endtask

  task automatic test_single_write();
    wq.push_back('{10, 8'h53});
    run_line(1'b0, LINE_TOT);
    checks++;
    if (cap_pix[10] !== 8'h00) begin
      errors++;
      $display("FAIL single_write_early: got %h, want 00", cap_pix[10]);
    end
    run_line(1'b0, LINE_TOT);
    checks++;
    if (cap_pix[10] !== 8'h53 || count_non_blank() != 1) begin
      errors++;
      $display("FAIL single_write_show: got %h (%0d non-blank), want 53 (1)",
               cap_pix[10], count_non_blank());
    end
    run_line(1'b0, LINE_TOT);
    checks++;
    if (cap_pix[10] !== 8'h00) begin
      errors++;
      $display("FAIL clear_behind: got %h, want 00", cap_pix[10]);
    end
  endtask

  task automatic test_dropped_writes();
    wq.push_back('{20, 8'h2F});
    wq.push_back('{300, 8'h44});
    run_line(1'b0, LINE_TOT);
    run_line(1'b0, LINE_TOT);
    checks++;
    if (count_non_blank() != 0) begin
      errors++;
      $display("FAIL dropped_writes: got %0d non-blank (hc20=%h hc44=%h), want 0",
               count_non_blank(), cap_pix[20], cap_pix[44]);
    end
  endtask

  task automatic test_overwrite();
    wq.push_back('{5, 8'h11});
    wq.push_back('{5, 8'h22});
    run_line(1'b0, LINE_TOT);
    run_line(1'b0, LINE_TOT);
    checks++;
    if (cap_pix[5] !== 8'h22) begin
      errors++;
      $display("FAIL overwrite: got %h, want 22", cap_pix[5]);
    end
  endtask

  task automatic test_write_on_swap();
    swap_wr = 1'b1; swap_x = 7; swap_d = 8'h77;
    run_line(1'b0, LINE_TOT);
    run_line(1'b0, LINE_TOT);
    checks++;
    if (cap_pix[7] !== 8'h00) begin
      errors++;
      $display("FAIL swap_write_early: got %h, want 00", cap_pix[7]);
    end
    run_line(1'b0, LINE_TOT);
    checks++;
    if (cap_pix[7] !== 8'h77) begin
      errors++;
      $display("FAIL swap_write_late: got %h, want 77", cap_pix[7]);
    end
  endtask

  task automatic test_vblank();
    int c;
    wq.push_back('{30, 8'h9A});
    run_line(1'b0, LINE_TOT);
    run_line(1'b1, LINE_TOT);
    c = 0;
    for (int i = 0; i < LINE_W; i++) if (cap_pix[i] !== 8'h00 || cap_pv[i] !== 1'b0) c++;
    checks++;
    if (c != 0) begin
      errors++;
      $display("FAIL vblank_line: got %0d shown pixels, want 0", c);
    end
    run_line(1'b0, LINE_TOT);
    run_line(1'b0, LINE_TOT);
    checks++;
    if (cap_pix[30] !== 8'h00 || cap_pv[30] !== 1'b1) begin
      errors++;
      $display("FAIL vblank_clear: got pix=%h pv=%b, want 00/1", cap_pix[30], cap_pv[30]);
    end
  endtask

  task automatic test_random();
    for (int l = 0; l < 8; l++) begin
      int nw;
      nw = int'($urandom_range(0, 12));
      for (int k = 0; k < nw; k++)
        wq.push_back('{int'($urandom_range(0, 299)), 8'($urandom)});
      if ($urandom_range(0, 2) == 0) begin
        swap_wr = 1'b1;
        swap_x = int'($urandom_range(0, 255));
        swap_d = 8'($urandom);
      end
      run_line($urandom_range(0, 3) == 0, LINE_TOT);
    end
  endtask

  task automatic test_reset_mid_line();
    int n;
    wq.push_back('{99, 8'hA5});
    run_line(1'b0, LINE_TOT);
    wq.push_back('{50, 8'h66});
    run_line(1'b0, 100);
    checks++;
    if (bus.pix_out !== 8'hA5) begin
      errors++;
      $display("FAIL pre_reset_pixel: got %h, want a5", bus.pix_out);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.ready, bus.line_start, bus.pix_valid, bus.pix_out} !== 11'b0) begin
      errors++;
      $display("FAIL mid_reset_values: got ready=%b ls=%b pv=%b pix=%h, want all 0",
               bus.ready, bus.line_start, bus.pix_valid, bus.pix_out);
    end
    do_reset(1'b0, n);
    checks++;
    if (n != 512) begin
      errors++;
      $display("FAIL mid_reset_ready: got cycle %0d, want 512", n);
    end
    for (int l = 0; l < 2; l++) begin
      run_line(1'b0, LINE_TOT);
      checks++;
      if (count_non_blank() != 0) begin
        errors++;
        $display("FAIL post_reset_line_%0d: got %0d non-blank, want 0", l, count_non_blank());
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_single_write();
    test_dropped_writes();
    test_overwrite();
    test_write_on_swap();
    test_vblank();
    test_random();
    test_reset_mid_line();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/sprite_line_buffer.md
# sprite_line_buffer

Ping-pong scanline buffer between the sprite renderer and the video mixer. It consumes the pixel-enable, horizontal count and blanking signals from the video timing generator. The sprite renderer draws line N+1 into one bank while the mixer reads line N from the other. Each display pixel is cleared to transparent immediately after it is read, so the bank is empty when it next becomes the write bank.

## Interface
- `LINE_W`, 256: visible pixels per line. Bank depth; addresses are `hc[7:0]`.
- `PIX_W`, 8: pixel width, `{colour[7:4], pen[3:0]}`.
- `clk` in 1: system clock. The only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `clk_pix` in 1: pixel enable, one `clk` wide. At least 2 `clk` separate successive enables.
- `hc` in 9: horizontal count from the timing generator.
- `hbl` in 1: horizontal blank.
- `vbl` in 1: vertical blank.
- `wr_en` in 1: renderer write strobe, one pixel per `clk`.
- `wr_x` in 9: renderer write x position.
- `wr_data` in PIX_W: renderer pixel.
- `ready` out 1: low during the post-reset clear sweep.
- `line_start` out 1: one-`clk` pulse on bank swap. The renderer starts the next line on this pulse.
- `pix_out` out PIX_W: display pixel to the mixer.
- `pix_valid` out 1: high when `pix_out` is an active-area pixel.

## Operation
- Storage: one 2×LINE_W×PIX_W dual-port RAM, MSB = bank.
  - `sel` selects the display bank; the write bank is `~sel`.
- FSM states: INIT, RUN.
  - INIT: sweep counter 0..2·LINE_W−1 writes 8'h0F to every address (pen F = transparent). `wr_en` is ignored.
  - INIT → RUN after the last address; `ready` rises in the same cycle.
- RUN, write side (port B):
  - On `wr_en`, write `wr_data` to `{~sel, wr_x[7:0]}`.
  - Drop the write if `wr_x >= LINE_W` or `wr_data[3:0] == 4'hF`.
  - Later writes overwrite earlier ones; the renderer submits back-to-front.
- RUN, display side (port A):
  - On a `clk_pix` cycle with `hbl == 0`, read `{sel, hc[7:0]}`.
  - On the next `clk`, register the read data into `pix_out`, set `pix_valid = ~vbl`, and write 8'h0F back to the same address (clear-behind).
  - When `vbl == 1`, the read and clear still run but `pix_out` is forced to 0. Both banks therefore keep cycling through blanking.
  - On a `clk_pix` cycle with `hbl == 1`, set `pix_out` = 0 and `pix_valid` = 0.
- Swap:
  - `hbl_d` is sampled on `clk_pix`.
  - On a `clk_pix` cycle with `hbl & ~hbl_d`, toggle `sel` and pulse `line_start` on the next `clk`.
- A write in the same `clk` as the `sel` toggle goes to the new write bank (the old display bank). The last clear has completed by then, so no port conflict is possible.
- Ports A and B always address different banks in RUN. No same-address collision arbitration is needed.
- Widths: all address arithmetic is 9-bit unsigned; `wr_x` is never wrapped.

## Timing
- Reset values (asynchronous): `sel`=0, `hbl_d`=0, state=INIT, sweep=0, `ready`=0, `line_start`=0, `pix_out`=0, `pix_valid`=0. RAM contents are not reset; the INIT sweep clears them.
- Reset asserted mid-line: all of the above values are reapplied, and the sweep restarts from 0.
- INIT duration: 2·LINE_W `clk` after `reset_n` deasserts (512 cycles at default).
- Read latency: `pix_out` updates one `clk` after the `clk_pix` cycle presenting `hc`. It holds until the next update.
- Clear: one `clk` after the read, the same cycle `pix_out` updates.
- `line_start`: one `clk` after the swap `clk_pix` cycle. High for exactly 1 `clk`.
- Write: visible on the display side from the line after the next swap.

## Structure
- Shared package `video_pkg`:
  - constants `LINE_W`, `PIX_W`, `PEN_TRANSPARENT` (4'hF), `PIX_CLEAR` (8'h0F);
  - FSM state enum {INIT, RUN}.
- Sub-module `line_ram`: simple dual-port synchronous RAM, 2·LINE_W×PIX_W, read-first on port A and write-only on port B. No reset.
- Top level holds the FSM, sweep counter, swap logic and output registers.

## Test plan
- Reset, then 512 `clk` -> `ready` rises at cycle 512. A full line read returns `pix_out`=0 and `pix_valid`=1 for hc 0..255.
- After `line_start`, write `wr_x`=10, `wr_data`=8'h53 -> the next line shows `pix_out`=8'h53 at hc=10 and 0 elsewhere. The line after shows 0 at hc=10 (clear-behind).
- Write `wr_data`=8'h2F at x=20, and 8'h44 at `wr_x`=300 -> neither appears; the display line is all 0.
- Write x=5 with 8'h11, then x=5 with 8'h22, same line -> the display shows 8'h22.
- Issue `wr_en` in the exact `clk` of the `sel` toggle at x=7 -> the pixel appears one line later, not on the currently displayed line.
- Assert `reset_n`=0 at hc=100 with data pending -> outputs go to reset values immediately. After 512 `clk` the first line is all 0.
